// File: rtl/mpu_xfer_seq_pkg.sv
// Shared types and constants for the MPU transfer sequencer: FSM encoding,
// latched transfer header layout and default widths.
package mpu_xfer_seq_pkg;

  localparam int XFER_DATA_W    = 32;
  localparam int XFER_ADDR_W    = 16;
  localparam int XFER_LEN_W     = 16;
  localparam int MAX_OUTST_XFER = 4;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LEN,
    HDR_STRIDE,
    HDR_BASE,
    ST_XFER,
    LD_XFER,
    DONE
  } fsm_xfer_t;

  typedef struct packed {
    logic [XFER_LEN_W-1:0]  len;
    logic [XFER_ADDR_W-1:0] stride;
    logic [XFER_ADDR_W-1:0] base;
  } xfer_hdr_t;

endpackage

// File: rtl/mpu_xfer_fifo.sv
// Small synchronous FIFO buffering store payload words ahead of memory writes.
// Flush empties it in one cycle; a push while full is accepted only alongside a pop.
module mpu_xfer_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset || flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mpu_xfer_seq.sv
// Transfer sequencer behind the MPU host interface: parses the 3-word header,
// issues strided memory writes/reads and returns load data plus End pulses.
module mpu_xfer_seq
  import mpu_xfer_seq_pkg::*;
#(
  parameter int WIDTH_DATA  = XFER_DATA_W,
  parameter int WIDTH_ADDR  = XFER_ADDR_W,
  parameter int WIDTH_LEN   = XFER_LEN_W,
  parameter int MAX_OUTST   = MAX_OUTST_XFER,
  parameter int DEPTH_SFIFO = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Start_St,
  input  logic                  I_Start_Ld,
  input  logic                  I_Abort,
  input  logic                  I_Req,
  input  logic [WIDTH_DATA-1:0] I_Data,
  output logic                  O_Req_Mem,
  output logic                  O_We_Mem,
  output logic [WIDTH_ADDR-1:0] O_Addr_Mem,
  output logic [WIDTH_DATA-1:0] O_WData_Mem,
  input  logic                  I_Rdy_Mem,
  input  logic                  I_RVld_Mem,
  input  logic [WIDTH_DATA-1:0] I_RData_Mem,
  output logic                  O_Req,
  output logic [WIDTH_DATA-1:0] O_Data,
  output logic                  O_End_St,
  output logic                  O_End_Ld,
  output logic                  O_Busy,
  output logic                  O_Err
);
  localparam int OW = 4;
  localparam logic [OW-1:0]        OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [OW-1:0]        OUTST_ONE = 1;
  localparam logic [OW:0]          STALE_ONE = 1;
  localparam logic [WIDTH_LEN-1:0] LEN_ONE   = 1;

  fsm_xfer_t             state_q, state_d;
  xfer_hdr_t             hdr_q, hdr_d;
  logic                  dir_st_q, dir_st_d;
  logic [WIDTH_ADDR-1:0] off_q, off_d;
  logic [WIDTH_LEN-1:0]  issued_q, issued_d, done_q, done_d;
  logic [OW-1:0]         outst_q, outst_d;
  logic [OW:0]           stale_q, stale_d;
  logic                  err_q, err_d;

  logic in_st, in_ld, fifo_full, fifo_empty;
  logic push_req, push, pop, overflow, rd_issue, rd_acc, req_mem, mem_acc;
  logic rsp_stale, rsp_real, rsp_orphan, last_wr, last_rsp;
  logic [WIDTH_LEN:0]  done_inc;
  logic [WIDTH_DATA-1:0] fifo_head;

  assign in_st = (state_q == ST_XFER);
  assign in_ld = (state_q == LD_XFER);

  // In a store, issued_q counts words admitted into the FIFO; a dropped word
  // does not count, so the host must keep supplying words until len are written.
  assign push_req = in_st && I_Req && (issued_q < hdr_q.len);
  assign pop      = in_st && !fifo_empty && I_Rdy_Mem;
  assign push     = push_req && (!fifo_full || pop);
  assign overflow = push_req && fifo_full && !pop;
  assign rd_issue = in_ld && (issued_q < hdr_q.len) && (outst_q < OUTST_MAX);
  assign rd_acc   = rd_issue && I_Rdy_Mem;
  assign req_mem  = (in_st && !fifo_empty) || rd_issue;
  assign mem_acc  = req_mem && I_Rdy_Mem;

  // Responses owed to an aborted load drain through stale_q before any new read counts.
  assign rsp_stale  = I_RVld_Mem && (stale_q != '0);
  assign rsp_real   = I_RVld_Mem && (stale_q == '0) && (outst_q != '0);
  assign rsp_orphan = I_RVld_Mem && (stale_q == '0) && (outst_q == '0);
  assign done_inc   = {1'b0, done_q} + {1'b0, LEN_ONE};
  assign last_wr    = pop && (done_inc == {1'b0, hdr_q.len});
  assign last_rsp   = in_ld && rsp_real && (done_inc == {1'b0, hdr_q.len});

  mpu_xfer_fifo #(
    .WIDTH (WIDTH_DATA),
    .DEPTH (DEPTH_SFIFO)
  ) u_sfifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (I_Abort),
    .wdata (I_Data),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign O_Req_Mem   = req_mem;
  assign O_We_Mem    = in_st && !fifo_empty;
  assign O_Addr_Mem  = req_mem ? (hdr_q.base + off_q) : '0;
  assign O_WData_Mem = O_We_Mem ? fifo_head : '0;
  assign O_Req       = in_ld && rsp_real;
  assign O_Data      = O_Req ? I_RData_Mem : '0;
  assign O_End_St    = (state_q == DONE) && dir_st_q && !I_Abort;
  assign O_End_Ld    = (state_q == DONE) && !dir_st_q && !I_Abort;
  assign O_Busy      = (state_q != IDLE);
  assign O_Err       = err_q;

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    dir_st_d = dir_st_q;
    off_d    = off_q;
    issued_d = issued_q;
    done_d   = done_q;
    outst_d  = outst_q;
    stale_d  = stale_q;
    err_d    = err_q;

    if (mem_acc)          off_d    = off_q + hdr_q.stride;
    if (push || rd_acc)   issued_d = issued_q + LEN_ONE;
    if (pop || rsp_real)  done_d   = done_q + LEN_ONE;
    if (rd_acc)           outst_d  = outst_d + OUTST_ONE;
    if (rsp_real)         outst_d  = outst_d - OUTST_ONE;
    if (rsp_stale)        stale_d  = stale_q - STALE_ONE;
    if (overflow || rsp_orphan) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (I_Start_St || I_Start_Ld) begin
          state_d  = HDR_LEN;
          dir_st_d = I_Start_St;
          err_d    = 1'b0;
          issued_d = '0;
          done_d   = '0;
          off_d    = '0;
        end
      end
      HDR_LEN: begin
        if (I_Req) begin
          hdr_d.len = I_Data[WIDTH_LEN-1:0];
          state_d   = HDR_STRIDE;
        end
      end
      HDR_STRIDE: begin
        if (I_Req) begin
          hdr_d.stride = I_Data[WIDTH_ADDR-1:0];
          state_d      = HDR_BASE;
        end
      end
      HDR_BASE: begin
        if (I_Req) begin
          hdr_d.base = I_Data[WIDTH_ADDR-1:0];
          if (hdr_q.len == '0) state_d = DONE;
          else if (dir_st_q)   state_d = ST_XFER;
          else                 state_d = LD_XFER;
        end
      end
      ST_XFER: if (last_wr)  state_d = DONE;
      LD_XFER: if (last_rsp) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (I_Abort) begin
      state_d = IDLE;
      stale_d = stale_d + {1'b0, outst_d};
      outst_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      dir_st_q <= 1'b0;
      issued_q <= '0;
      done_q   <= '0;
      outst_q  <= '0;
      stale_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_st_q <= dir_st_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      outst_q  <= outst_d;
      stale_q  <= stale_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    hdr_q <= hdr_d;
    off_q <= off_d;
  end

endmodule

// File: tb/tb_mpu_xfer_seq.sv
// Randomized bench for mpu_xfer_seq: a transaction-level model predicts addresses,
// write data, load data, End timing, busy/error flags and outstanding-read limits.
module tb_mpu_xfer_seq;
  localparam int DW = 32, AW = 16, DEPTH = 4, MAXO = 4;

  logic clock = 1'b0;
  logic reset;
  logic I_Start_St, I_Start_Ld, I_Abort, I_Req;
  logic [DW-1:0] I_Data;
  logic O_Req_Mem, O_We_Mem;
  logic [AW-1:0] O_Addr_Mem;
  logic [DW-1:0] O_WData_Mem;
  logic I_Rdy_Mem, I_RVld_Mem;
  logic [DW-1:0] I_RData_Mem;
  logic O_Req;
  logic [DW-1:0] O_Data;
  logic O_End_St, O_End_Ld, O_Busy, O_Err;

  int n_cmp = 0;
  int n_mis = 0;
  bit err_m = 1'b0;

  always #5 clock = ~clock;

  mpu_xfer_seq #(
    .WIDTH_DATA (DW), .WIDTH_ADDR (AW), .WIDTH_LEN (16), .MAX_OUTST (MAXO), .DEPTH_SFIFO (DEPTH)
  ) dut (
    .clock (clock), .reset (reset),
    .I_Start_St (I_Start_St), .I_Start_Ld (I_Start_Ld), .I_Abort (I_Abort),
    .I_Req (I_Req), .I_Data (I_Data),
    .O_Req_Mem (O_Req_Mem), .O_We_Mem (O_We_Mem), .O_Addr_Mem (O_Addr_Mem),
    .O_WData_Mem (O_WData_Mem), .I_Rdy_Mem (I_Rdy_Mem), .I_RVld_Mem (I_RVld_Mem),
    .I_RData_Mem (I_RData_Mem), .O_Req (O_Req), .O_Data (O_Data),
    .O_End_St (O_End_St), .O_End_Ld (O_End_Ld), .O_Busy (O_Busy), .O_Err (O_Err)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] memval(input logic [15:0] a);
    return {a, ~a} ^ 32'hA5C3_0F1E;
  endfunction

  task automatic drive_idle();
    I_Start_St = 1'b0; I_Start_Ld = 1'b0; I_Abort = 1'b0; I_Req = 1'b0;
    I_Data = '0; I_Rdy_Mem = 1'b0; I_RVld_Mem = 1'b0; I_RData_Mem = '0;
    reset = 1'b1;
  endtask

  // kill_kind: 0 none, 1 abort once kill_arg reads are outstanding,
  // 2 reset kill_arg cycles into the payload phase.
  task automatic do_xfer(input bit st, input int len, input logic [15:0] stride,
                         input logic [15:0] base, input int rdy_pct, input int lat_lo,
                         input int lat_hi, input int req_pct, input int stall,
                         input int kill_kind, input int kill_arg);
    logic [31:0] mq[$];
    int          pend_due[$];
    logic [15:0] pend_addr[$];
    logic [31:0] hdr_w [3];
    int cyc = 0, hdr_idx = 0, xfer_start = -1, end_cyc = -1, kill_cyc = -1;
    int acc = 0, pushed = 0, resp = 0, outst = 0, last_due = -1, due, pre_size;
    bit xfer = 0, busy_m = 0, killed = 0, done = 0;
    bit reset_now, abort_now, rsp_now, rsp_real, exp_rm, acc_now;
    logic [15:0] exp_a;

    hdr_w[0] = ($urandom() & 32'hFFFF_0000) | (32'(len) & 32'h0000_FFFF);
    hdr_w[1] = ($urandom() & 32'hFFFF_0000) | {16'h0, stride};
    hdr_w[2] = ($urandom() & 32'hFFFF_0000) | {16'h0, base};

    while (!done) begin
      @(negedge clock);
      abort_now = (!killed && xfer && kill_kind == 1 && outst == kill_arg);
      reset_now = (!killed && xfer && kill_kind == 2 && (cyc - xfer_start) == kill_arg);
      I_Start_St = (cyc == 0) ? st  : (busy_m && $urandom_range(9) == 0);
      I_Start_Ld = (cyc == 0) ? !st : (busy_m && $urandom_range(9) == 0);
      I_Abort = abort_now;
      reset = !reset_now;
      I_Req = 1'b0;
      I_Data = $urandom();
      if (busy_m && hdr_idx < 3) begin
        I_Req = ($urandom_range(99) < req_pct);
        I_Data = hdr_w[hdr_idx];
      end else if (xfer && st) begin
        I_Req = ($urandom_range(99) < req_pct);
      end
      I_Rdy_Mem = (xfer_start >= 0 && cyc < xfer_start + stall) ? 1'b0
                                                                  : ($urandom_range(99) < rdy_pct);
      rsp_now = (pend_due.size() > 0) && (pend_due[0] == cyc);
      I_RVld_Mem = rsp_now;
      I_RData_Mem = rsp_now ? memval(pend_addr[0]) : $urandom();
      #1;

      exp_rm = xfer && (st ? (mq.size() > 0) : (acc < len && outst < MAXO));
      exp_a  = base + 16'(acc) * stride;
      chk("req_mem", 32'(O_Req_Mem), 32'(exp_rm));
      if (exp_rm) begin
        chk("addr", 32'(O_Addr_Mem), 32'(exp_a));
        chk("we", 32'(O_We_Mem), 32'(st));
        if (st) chk("wdata", O_WData_Mem, mq[0]);
      end
      rsp_real = rsp_now && xfer && !st;
      chk("o_req", 32'(O_Req), 32'(rsp_real));
      chk("o_data", O_Data, rsp_real ? memval(pend_addr[0]) : 32'h0);
      chk("end_st", 32'(O_End_St), 32'(st && cyc == end_cyc));
      chk("end_ld", 32'(O_End_Ld), 32'(!st && cyc == end_cyc));
      chk("busy", 32'(O_Busy), 32'(busy_m));
      chk("err", 32'(O_Err), 32'(err_m));
      if (killed && kill_kind == 2 && cyc == kill_cyc + 1) begin
        chk("rst_addr", 32'(O_Addr_Mem), 32'h0);
        chk("rst_wdata", O_WData_Mem, 32'h0);
      end

      acc_now  = exp_rm && I_Rdy_Mem;
      pre_size = mq.size();
      if (acc_now) begin
        acc++;
        if (st) begin
          void'(mq.pop_front());
          if (acc == len) begin end_cyc = cyc + 1; xfer = 0; end
        end else begin
          outst++;
          due = cyc + int'($urandom_range(lat_hi, lat_lo));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend_due.push_back(due);
          pend_addr.push_back(exp_a);
        end
      end
      if (xfer_start >= 0 && cyc >= xfer_start && !killed && st && I_Req && pushed < len) begin
        if (pre_size < DEPTH || acc_now) begin
          mq.push_back(I_Data);
          pushed++;
        end else begin
          err_m = 1'b1;
        end
      end
      if (rsp_now) begin
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
        if (rsp_real) begin
          outst--;
          resp++;
          if (resp == len) begin end_cyc = cyc + 1; xfer = 0; end
        end
      end
      if (busy_m && hdr_idx < 3 && I_Req) begin
        hdr_idx++;
        if (hdr_idx == 3) begin
          if (len == 0) end_cyc = cyc + 1;
          else begin xfer = 1; xfer_start = cyc + 1; end
        end
      end
      if (cyc == 0) begin busy_m = 1; err_m = 1'b0; end
      else if (cyc == end_cyc) busy_m = 0;
      if (abort_now || reset_now) begin
        killed = 1; kill_cyc = cyc; xfer = 0; end_cyc = -1; busy_m = 0;
        mq.delete();
        if (reset_now) err_m = 1'b0;
      end

      cyc++;
      if (end_cyc >= 0 && cyc > end_cyc + 1 && pend_due.size() == 0) done = 1;
      if (killed && cyc > kill_cyc + 2 && pend_due.size() == 0) done = 1;
      if (cyc > 3000) begin
        chk("timeout", 32'(cyc), 32'(0));
        done = 1;
      end
    end
    @(negedge clock);
    drive_idle();
  endtask

  initial begin
    drive_idle();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk("rst_req_mem", 32'(O_Req_Mem), 32'h0);
    chk("rst_we", 32'(O_We_Mem), 32'h0);
    chk("rst_addr0", 32'(O_Addr_Mem), 32'h0);
    chk("rst_wdata0", O_WData_Mem, 32'h0);
    chk("rst_oreq", 32'(O_Req), 32'h0);
    chk("rst_odata", O_Data, 32'h0);
    chk("rst_end_st", 32'(O_End_St), 32'h0);
    chk("rst_end_ld", 32'(O_End_Ld), 32'h0);
    chk("rst_busy", 32'(O_Busy), 32'h0);
    chk("rst_err", 32'(O_Err), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    do_xfer(1, 3, 16'h0002, 16'h0010, 100, 1, 1, 100, 0, 0, 0);
    do_xfer(0, 5, 16'h0001, 16'hFFFE, 100, 3, 3, 100, 0, 0, 0);
    do_xfer(1, 8, 16'h0001, 16'h0100, 100, 1, 1, 100, 6, 0, 0);
    do_xfer(1, 0, 16'h0003, 16'h0200, 100, 1, 1, 100, 0, 0, 0);
    do_xfer(0, 0, 16'h0003, 16'h0300, 100, 1, 1, 100, 0, 0, 0);
    do_xfer(0, 10, 16'h0004, 16'h0400, 100, 6, 6, 100, 0, 1, 3);
    do_xfer(0, 4, 16'h0005, 16'h0500, 100, 2, 4, 100, 0, 0, 0);
    do_xfer(0, 3, 16'hFFFF, 16'h0002, 100, 1, 2, 100, 0, 0, 0);
    do_xfer(1, 6, 16'h0001, 16'h0600, 50, 1, 1, 100, 0, 2, 2);
    do_xfer(1, 2, 16'h0007, 16'h0700, 100, 1, 1, 100, 0, 0, 0);

    for (int t = 0; t < 24; t++) begin
      bit rst_st;
      int kk;
      rst_st = 1'($urandom_range(1));
      kk = (!rst_st && $urandom_range(3) == 0) ? 1 : 0;
      do_xfer(rst_st, int'($urandom_range(12)), 16'($urandom()), 16'($urandom()),
              int'($urandom_range(100, 40)), 1, int'($urandom_range(5, 1)),
              int'($urandom_range(100, 50)), 0, kk, int'($urandom_range(3, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
